alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU operand interface: accepts RV32I OP/OP-IMM instrs + register values over valid/ready,
//  decodes them to alu_op/op1/op2, drives the combinational alu, and registers the result to a valid/ready writeback port.
//  Sits between operand fetch and register-file writeback; 2-stage pipeline (E: issue reg, W: result reg), 1 op/cycle.
// PARAMETERS
//  CNT_W    16  width of retired-op counter (wraps)
//  ZERO_X0  1   1: result for rd==0 forced to 32'd0 on out_data
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  in_valid     in   1   instr/operands valid
//  in_ready     out  1   block accepts when in_valid&in_ready at clk edge
//  in_instr     in   32  RV32I instruction word
//  in_rs1_val   in   32  rs1 register value
//  in_rs2_val   in   32  rs2 register value (ignored for OP-IMM)
//  alu_op       out  4   to alu: operation code
//  alu_op1      out  32  to alu: operand 1
//  alu_op2      out  32  to alu: operand 2
//  alu_result   in   32  from alu: combinational result of registered alu_* outputs
//  out_valid    out  1   writeback valid
//  out_ready    in   1   writeback consumer ready
//  out_rd       out  5   destination register
//  out_data     out  32  result
//  out_illegal  out  1   instr not a legal OP/OP-IMM ALU op
//  retire_cnt   out  CNT_W  count of out handshakes
// BEHAVIOUR
//  Reset (async, immediate): e_valid=0, out_valid=0, alu_op/alu_op1/alu_op2=0, out_rd=0, out_data=0, out_illegal=0,
//   retire_cnt=0. Reset mid-operation drops all in-flight ops; nothing is replayed.
//  Codes: ADD 0000 SUB 0001 AND 0010 OR 0011 XOR 0100 SLL 0101 SRL 0110 SRA 0111 SLT 1000 SLTU 1001.
//  Decode: opcode 0110011 (OP): op2=rs2_val; opcode 0010011 (OP-IMM): op2=sign-ext instr[31:20]. op1=rs1_val.
//   funct3 000 ADD (SUB if OP & funct7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA (funct7 0000000/0100000);
//   110 OR; 111 AND. OP-IMM shifts: op2={27'b0,instr[24:20]}.
//  Illegal: other opcode; OP funct7 not 0000000 (or 0100000 for ADD/SRL); OP-IMM shift funct7 likewise.
//   Illegal ops still flow through: alu_op=0, op1=op2=0, out_data=0, out_illegal=1.
//  Pipeline: w_adv = !out_valid | out_ready; in_ready = !e_valid | w_adv (combinational, no in_valid dependency).
//   Accept at edge N -> E regs (alu_*) loaded at N; alu_result sampled into W at edge N+1; out_valid high after N+1.
//   Latency 2 edges in->out; back-to-back throughput 1/cycle when out_ready held high.
//  Stall: out_valid&!out_ready holds W and E (alu_* stable, so alu_result stable); in_ready=0 only if E also full.
//  Bubble: E advances to W and E empties when no new accept; alu_* outputs hold last values (don't-care to alu).
//  out_* stable while out_valid&!out_ready (AXI-style; no retraction).
//  ZERO_X0=1 and rd==0: out_data=0, out_valid still asserted, out_illegal per decode.
//  retire_cnt += 1 on out_valid&out_ready; wraps 2^CNT_W-1 -> 0.
//  Simultaneous accept + W handshake in same cycle: both occur, no loss, no duplication.
// STRUCTURE
//  Package alu_pkg: 4-bit ALU op localparams (above), OPC_OP=7'b0110011, OPC_OPIMM=7'b0010011,
//   FUNCT7_BASE/ALT; shared with the alu itself.
//  Sub-module alu_decode (combinational): instr, rs1_val, rs2_val -> alu_op, op1, op2, rd, illegal.
//  Top holds E/W regs, handshake logic, retire counter.
// TESTING
//  Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, retire_cnt=0 immediately, no output after release.
//  OP ADD x3,x1,x2 rs1=5 rs2=7, out_ready=1 -> out_valid 2 edges later, out_rd=3, out_data=12; SUB same -> 0xFFFFFFFE.
//  OP-IMM SRAI x4,x1,4 rs1=0x80000000 -> 0xF8000000; ADDI imm=0xFFF rs1=1 -> 0; SLTIU imm=-1 rs1=5 -> 1.
//  Illegal: opcode 0110111 or OP funct7=0000001 -> out_illegal=1, out_data=0; rd=0 ADD 1+1 -> out_data=0.
//  Backpressure: 8 back-to-back ADDs, out_ready toggled 1/0 -> all 8 results in order, in_ready low only with E&W full,
//   out_* stable while stalled, retire_cnt=8.
//  Counter wrap: CNT_W=4, 17 handshakes -> retire_cnt=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared RV32I ALU definitions: operation codes, opcode/funct constants and
// the issue/writeback payload structs used by the issue controller.
package alu_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ALU_OP_W = 4;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned IMM_W    = 12;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam alu_op_t ALU_ADD  = 4'b0000;
   localparam alu_op_t ALU_SUB  = 4'b0001;
   localparam alu_op_t ALU_AND  = 4'b0010;
   localparam alu_op_t ALU_OR   = 4'b0011;
   localparam alu_op_t ALU_XOR  = 4'b0100;
   localparam alu_op_t ALU_SLL  = 4'b0101;
   localparam alu_op_t ALU_SRL  = 4'b0110;
   localparam alu_op_t ALU_SRA  = 4'b0111;
   localparam alu_op_t ALU_SLT  = 4'b1000;
   localparam alu_op_t ALU_SLTU = 4'b1001;

   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Contents of the E stage: what the alu sees plus the tags carried along.
   typedef struct packed {
      alu_op_t           op;
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic [REG_AW-1:0] rd;
      logic              illegal;
   } issue_t;

   // Contents of the W stage presented on the writeback port.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
      logic              illegal;
   } wb_t;

   function automatic logic [XLEN-1:0] sext_imm12(input logic [IMM_W-1:0] imm);
      return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I OP/OP-IMM decoder: instruction + register values to
// alu operation, operands, destination register and an illegal flag.
module alu_decode
   import alu_pkg::*;
(
   input  logic [XLEN-1:0]   instr_i,
   input  logic [XLEN-1:0]   rs1_val_i,
   input  logic [XLEN-1:0]   rs2_val_i,
   output alu_op_t           alu_op_o,
   output logic [XLEN-1:0]   op1_o,
   output logic [XLEN-1:0]   op2_o,
   output logic [REG_AW-1:0] rd_o,
   output logic              illegal_o
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            is_op;
   logic            is_opimm;
   logic            f7_base;
   logic            f7_alt;
   logic            shamt_form;
   logic            legal;
   alu_op_t         op_sel;
   logic [XLEN-1:0] op2_raw;

   // Source register indices are resolved upstream; only the values arrive here.
   logic unused_rs1_field;
   assign unused_rs1_field = ^instr_i[19:15];

   assign opcode   = instr_i[6:0];
   assign funct3   = instr_i[14:12];
   assign funct7   = instr_i[31:25];
   assign is_op    = (opcode == OPC_OP);
   assign is_opimm = (opcode == OPC_OPIMM);
   assign f7_base  = (funct7 == FUNCT7_BASE);
   assign f7_alt   = (funct7 == FUNCT7_ALT);

   // Operation select and funct7 legality; OP-IMM only constrains funct7 on shifts.
   always_comb begin
      op_sel = ALU_ADD;
      legal  = 1'b0;
      case (funct3)
         F3_ADD: begin
            op_sel = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
            legal  = is_opimm || f7_base || f7_alt;
         end
         F3_SLL: begin
            op_sel = ALU_SLL;
            legal  = f7_base;
         end
         F3_SLT: begin
            op_sel = ALU_SLT;
            legal  = is_opimm || f7_base;
         end
         F3_SLTU: begin
            op_sel = ALU_SLTU;
            legal  = is_opimm || f7_base;
         end
         F3_XOR: begin
            op_sel = ALU_XOR;
            legal  = is_opimm || f7_base;
         end
         F3_SR: begin
            op_sel = f7_alt ? ALU_SRA : ALU_SRL;
            legal  = f7_base || f7_alt;
         end
         F3_OR: begin
            op_sel = ALU_OR;
            legal  = is_opimm || f7_base;
         end
         F3_AND: begin
            op_sel = ALU_AND;
            legal  = is_opimm || f7_base;
         end
         default: begin
            op_sel = ALU_ADD;
            legal  = 1'b0;
         end
      endcase
      legal = legal && (is_op || is_opimm);
   end

   assign shamt_form = is_opimm && ((funct3 == F3_SLL) || (funct3 == F3_SR));

   always_comb begin
      op2_raw = sext_imm12(instr_i[31:20]);
      if (is_op) begin
         op2_raw = rs2_val_i;
      end else if (shamt_form) begin
         op2_raw = {(XLEN-5)'(0), instr_i[24:20]};
      end
   end

   // Illegal instructions present a zero ADD so the alu output is benign.
   assign alu_op_o  = legal ? op_sel    : ALU_ADD;
   assign op1_o     = legal ? rs1_val_i : '0;
   assign op2_o     = legal ? op2_raw   : '0;
   assign rd_o      = instr_i[11:7];
   assign illegal_o = ~legal;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: valid/ready operand intake, E stage driving the
// external alu, W stage holding the writeback result, and a retire counter.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter bit          ZERO_X0 = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_instr,
   input  logic [XLEN-1:0]    in_rs1_val,
   input  logic [XLEN-1:0]    in_rs2_val,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [XLEN-1:0]    alu_op1,
   output logic [XLEN-1:0]    alu_op2,
   input  logic [XLEN-1:0]    alu_result,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [REG_AW-1:0]  out_rd,
   output logic [XLEN-1:0]    out_data,
   output logic               out_illegal,
   output logic [CNT_W-1:0]   retire_cnt
);

   issue_t dec;

   logic       e_valid_q, e_valid_d;
   issue_t     e_q, e_d;
   logic       w_valid_q, w_valid_d;
   wb_t        w_q, w_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic            w_adv;
   logic            accept;
   logic            w_fire;
   logic [XLEN-1:0] wb_data;

   alu_decode u_decode (
      .instr_i   (in_instr),
      .rs1_val_i (in_rs1_val),
      .rs2_val_i (in_rs2_val),
      .alu_op_o  (dec.op),
      .op1_o     (dec.op1),
      .op2_o     (dec.op2),
      .rd_o      (dec.rd),
      .illegal_o (dec.illegal)
   );

   // W can take a new value when empty or when its current value leaves now.
   assign w_adv    = !w_valid_q || out_ready;
   assign in_ready = !e_valid_q || w_adv;
   assign accept   = in_valid && in_ready;
   assign w_fire   = w_valid_q && out_ready;

   always_comb begin
      wb_data = alu_result;
      if (e_q.illegal || (ZERO_X0 && (e_q.rd == '0))) begin
         wb_data = '0;
      end
   end

   // Next state for both stages and the counter.
   always_comb begin
      e_valid_d = e_valid_q;
      e_d       = e_q;
      w_valid_d = w_valid_q;
      w_d       = w_q;
      cnt_d     = cnt_q;

      if (in_ready) begin
         e_valid_d = in_valid;
      end
      // Without a new accept the alu inputs keep their last values.
      if (accept) begin
         e_d = dec;
      end

      if (w_adv) begin
         w_valid_d = e_valid_q;
         if (e_valid_q) begin
            w_d.rd      = e_q.rd;
            w_d.data    = wb_data;
            w_d.illegal = e_q.illegal;
         end
      end

      if (w_fire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_valid_q <= 1'b0;
         e_q       <= '0;
         w_valid_q <= 1'b0;
         w_q       <= '0;
         cnt_q     <= '0;
      end else begin
         e_valid_q <= e_valid_d;
         e_q       <= e_d;
         w_valid_q <= w_valid_d;
         w_q       <= w_d;
         cnt_q     <= cnt_d;
      end
   end

   assign alu_op      = e_q.op;
   assign alu_op1     = e_q.op1;
   assign alu_op2     = e_q.op2;
   assign out_valid   = w_valid_q;
   assign out_rd      = w_q.rd;
   assign out_data    = w_q.data;
   assign out_illegal = w_q.illegal;
   assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized + directed bench for alu_issue_ctrl with a behavioural alu and
// an instruction-level reference model feeding an in-order expectation queue.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr, in_rs1_val, in_rs2_val;
   logic [3:0]  alu_op;
   logic [31:0] alu_op1, alu_op2, alu_result;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic        out_illegal;
   logic [15:0] retire_cnt;

   logic        unused_in_ready4;
   logic [3:0]  unused_alu_op4;
   logic [31:0] unused_alu_op14, unused_alu_op24, alu_result4;
   logic        unused_out_valid4;
   logic [4:0]  unused_out_rd4;
   logic [31:0] unused_out_data4;
   logic        unused_out_illegal4;
   logic [3:0]  retire_cnt4;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.CNT_W(16), .ZERO_X0(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_data(out_data), .out_illegal(out_illegal), .retire_cnt(retire_cnt)
   );

   alu_issue_ctrl #(.CNT_W(4), .ZERO_X0(1'b1)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(unused_in_ready4),
      .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .alu_op(unused_alu_op4), .alu_op1(unused_alu_op14), .alu_op2(unused_alu_op24),
      .alu_result(alu_result4),
      .out_valid(unused_out_valid4), .out_ready(out_ready), .out_rd(unused_out_rd4),
      .out_data(unused_out_data4), .out_illegal(unused_out_illegal4), .retire_cnt(retire_cnt4)
   );

   // Behavioural alu using the documented operation codes.
   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         4'd7: return 32'($signed(a) >>> b[4:0]);
         4'd8: return {31'd0, ($signed(a) < $signed(b))};
         4'd9: return {31'd0, (a < b)};
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result  = alu_f(alu_op, alu_op1, alu_op2);
   assign alu_result4 = alu_f(unused_alu_op4, unused_alu_op14, unused_alu_op24);

   // Architectural result of one instruction: {rd, illegal, data}.
   function automatic logic [37:0] ref_model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [31:0] b, res;
      logic        ill, isop;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
      isop = (opc == 7'h33);
      b = isop ? r2 : {{20{ins[31]}}, ins[31:20]};
      ill = 1'b0; res = 32'd0;
      if (opc != 7'h33 && opc != 7'h13) ill = 1'b1;
      else begin
         case (f3)
            3'd0: if (!isop || f7 == 7'h00) res = r1 + b;
                  else if (f7 == 7'h20) res = r1 - b;
                  else ill = 1'b1;
            3'd1: if (f7 == 7'h00) res = r1 << b[4:0]; else ill = 1'b1;
            3'd5: if (f7 == 7'h00) res = r1 >> b[4:0];
                  else if (f7 == 7'h20) res = 32'($signed(r1) >>> b[4:0]);
                  else ill = 1'b1;
            default: begin
               if (isop && f7 != 7'h00) ill = 1'b1;
               else case (f3)
                  3'd2: res = ($signed(r1) < $signed(b)) ? 32'd1 : 32'd0;
                  3'd3: res = (r1 < b) ? 32'd1 : 32'd0;
                  3'd4: res = r1 ^ b;
                  3'd6: res = r1 | b;
                  default: res = r1 & b;
               endcase
            end
         endcase
      end
      if (ill || rd == 5'd0) res = 32'd0;
      return {rd, ill, res};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int s, f;
      w = $urandom;
      s = $urandom_range(0, 9);
      f = $urandom_range(0, 3);
      if (s < 4) w[6:0] = 7'h33;
      else if (s < 8) w[6:0] = 7'h13;
      if (f < 2) w[31:25] = 7'h00;
      else if (f == 2) w[31:25] = 7'h20;
      return w;
   endfunction

   typedef struct { logic [4:0] rd; logic [31:0] data; logic ill; int acc; } exp_t;
   exp_t exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int edge_cnt = 0;
   int exp_retire = 0;

   logic        c_obs_in_ready, c_obs_out_valid, c_obs_ill, c_acc;
   logic [4:0]  c_obs_rd;
   logic [31:0] c_obs_data;
   logic [15:0] c_obs_cnt, c_exp_cnt;
   logic [67:0] c_obs_alu;
   logic        c_exp_in_ready, c_exp_out_valid;
   exp_t        c_exp;

   // One clock of stimulus; captures observed and expected values for the caller.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic ordy);
      exp_t e;
      logic [37:0] m;
      in_valid = v; in_instr = ins; in_rs1_val = r1; in_rs2_val = r2; out_ready = ordy;
      #1;
      c_obs_in_ready  = in_ready;
      c_obs_out_valid = out_valid;
      c_obs_rd = out_rd; c_obs_data = out_data; c_obs_ill = out_illegal;
      c_obs_cnt = retire_cnt;
      c_obs_alu = {alu_op, alu_op1, alu_op2};
      c_exp_in_ready  = !(exp_q.size() == 2 && !ordy);
      c_exp_out_valid = (exp_q.size() > 0) && (exp_q[0].acc < edge_cnt);
      c_exp_cnt = 16'(exp_retire);
      if (c_exp_out_valid) c_exp = exp_q[0];
      if (c_exp_out_valid && ordy) begin
         void'(exp_q.pop_front());
         exp_retire++;
      end
      c_acc = v && in_ready;
      if (c_acc) begin
         m = ref_model(ins, r1, r2);
         e.rd = m[37:33]; e.ill = m[32]; e.data = m[31:0]; e.acc = edge_cnt + 1;
         exp_q.push_back(e);
      end
      @(posedge clk);
      edge_cnt++;
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(posedge clk); edge_cnt++; #1;
      rst = 1'b0;
      exp_q.delete();
      exp_retire = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs1_val = '0; in_rs2_val = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({out_valid, out_rd, out_data, out_illegal} !== 39'd0) begin
         n_err++; $display("FAIL reset_out: got %b/%0d/%h/%b want all zero", out_valid, out_rd, out_data, out_illegal);
      end
      n_vec++;
      if ({alu_op, alu_op1, alu_op2} !== 68'd0) begin
         n_err++; $display("FAIL reset_alu: got %h/%h/%h want zero", alu_op, alu_op1, alu_op2);
      end
      n_vec++;
      if (retire_cnt !== 16'd0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_cnt_ready: got cnt %0d rdy %b want 0 1", retire_cnt, in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] ins [8];
      logic [31:0] r1 [8];
      logic [31:0] r2 [8];
      ins[0] = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}; r1[0] = 32'd5;          r2[0] = 32'd7;
      ins[1] = {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}; r1[1] = 32'd5;          r2[1] = 32'd7;
      ins[2] = {7'h20, 5'd4, 5'd1, 3'b101, 5'd4, 7'h13}; r1[2] = 32'h8000_0000;  r2[2] = 32'hFFFF_FFFF;
      ins[3] = {12'hFFF, 5'd1, 3'b000, 5'd5, 7'h13};     r1[3] = 32'd1;          r2[3] = 32'd9;
      ins[4] = {12'hFFF, 5'd1, 3'b011, 5'd6, 7'h13};     r1[4] = 32'd5;          r2[4] = 32'd0;
      ins[5] = {20'h12345, 5'd7, 7'h37};                  r1[5] = 32'd3;          r2[5] = 32'd4;
      ins[6] = {7'h01, 5'd2, 5'd1, 3'b000, 5'd8, 7'h33}; r1[6] = 32'd6;          r2[6] = 32'd7;
      ins[7] = {7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'h33}; r1[7] = 32'd1;          r2[7] = 32'd1;
      for (int i = 0; i < 11; i++) begin
         if (i < 8) cycle(1'b1, ins[i], r1[i], r2[i], 1'b1);
         else       cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
         n_vec++;
         if (c_obs_out_valid !== c_exp_out_valid) begin
            n_err++; $display("FAIL dir_valid[%0d]: got %b want %b", i, c_obs_out_valid, c_exp_out_valid);
         end
         if (c_exp_out_valid) begin
            n_vec++;
            if ({c_obs_rd, c_obs_ill, c_obs_data} !== {c_exp.rd, c_exp.ill, c_exp.data}) begin
               n_err++; $display("FAIL dir_data[%0d]: got rd%0d ill%b %h want rd%0d ill%b %h",
                                 i, c_obs_rd, c_obs_ill, c_obs_data, c_exp.rd, c_exp.ill, c_exp.data);
            end
         end
         n_vec++;
         if (c_obs_cnt !== c_exp_cnt) begin
            n_err++; $display("FAIL dir_cnt[%0d]: got %0d want %0d", i, c_obs_cnt, c_exp_cnt);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a [8];
      logic [31:0] b [8];
      int idx, start;
      logic prev_stall;
      logic [67:0] prev_alu;
      idx = 0; start = exp_retire; prev_stall = 1'b0; prev_alu = '0;
      for (int i = 0; i < 8; i++) begin a[i] = $urandom; b[i] = $urandom; end
      for (int cyc = 0; cyc < 60 && (idx < 8 || exp_q.size() > 0); cyc++) begin
         cycle(idx < 8, {7'h00, 5'd2, 5'd1, 3'b000, 5'(idx + 10), 7'h33},
               a[idx % 8], b[idx % 8], cyc[0]);
         if (c_acc) idx++;
         n_vec++;
         if (c_obs_in_ready !== c_exp_in_ready) begin
            n_err++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, c_obs_in_ready, c_exp_in_ready);
         end
         n_vec++;
         if (c_obs_out_valid !== c_exp_out_valid) begin
            n_err++; $display("FAIL bp_valid[%0d]: got %b want %b", cyc, c_obs_out_valid, c_exp_out_valid);
         end
         if (c_exp_out_valid) begin
            n_vec++;
            if ({c_obs_rd, c_obs_ill, c_obs_data} !== {c_exp.rd, c_exp.ill, c_exp.data}) begin
               n_err++; $display("FAIL bp_data[%0d]: got rd%0d %h want rd%0d %h",
                                 cyc, c_obs_rd, c_obs_data, c_exp.rd, c_exp.data);
            end
         end
         if (prev_stall) begin
            n_vec++;
            if (c_obs_alu !== prev_alu) begin
               n_err++; $display("FAIL bp_alu_hold[%0d]: got %h want %h", cyc, c_obs_alu, prev_alu);
            end
         end
         prev_stall = !c_exp_in_ready;
         prev_alu   = c_obs_alu;
      end
      #0;
      n_vec++;
      if (retire_cnt !== 16'(start + 8)) begin
         n_err++; $display("FAIL bp_retire: got %0d want %0d", retire_cnt, start + 8);
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 340; cyc++) begin
         if (cyc < 300)
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
                  1'($urandom_range(0, 9) < 7));
         else
            cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
         n_vec++;
         if (c_obs_in_ready !== c_exp_in_ready || c_obs_out_valid !== c_exp_out_valid) begin
            n_err++; $display("FAIL rnd_hs[%0d]: got rdy%b vld%b want rdy%b vld%b", cyc,
                              c_obs_in_ready, c_obs_out_valid, c_exp_in_ready, c_exp_out_valid);
         end
         if (c_exp_out_valid) begin
            n_vec++;
            if ({c_obs_rd, c_obs_ill, c_obs_data} !== {c_exp.rd, c_exp.ill, c_exp.data}) begin
               n_err++; $display("FAIL rnd_data[%0d]: got rd%0d ill%b %h want rd%0d ill%b %h",
                                 cyc, c_obs_rd, c_obs_ill, c_obs_data, c_exp.rd, c_exp.ill, c_exp.data);
            end
         end
         n_vec++;
         if (c_obs_cnt !== c_exp_cnt) begin
            n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", cyc, c_obs_cnt, c_exp_cnt);
         end
      end
   endtask

   task automatic test_reset_midstream();
      cycle(1'b1, {12'd3, 5'd1, 3'b000, 5'd9, 7'h13}, 32'd4, 32'd0, 1'b0);
      cycle(1'b1, {12'd5, 5'd1, 3'b000, 5'd9, 7'h13}, 32'd4, 32'd0, 1'b0);
      cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      n_vec++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL rst_pre: out_valid got %b want 1", out_valid);
      end
      rst = 1'b1;
      #2;
      n_vec++;
      if (out_valid !== 1'b0 || retire_cnt !== 16'd0) begin
         n_err++; $display("FAIL rst_async: got vld %b cnt %0d want 0 0", out_valid, retire_cnt);
      end
      @(posedge clk); edge_cnt++; #1;
      rst = 1'b0;
      exp_q.delete();
      exp_retire = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
         n_vec++;
         if (c_obs_out_valid !== 1'b0 || c_obs_cnt !== 16'd0) begin
            n_err++; $display("FAIL rst_after[%0d]: got vld %b cnt %0d want 0 0", i, c_obs_out_valid, c_obs_cnt);
         end
      end
   endtask

   task automatic test_counter_wrap();
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         if (i < 17) cycle(1'b1, {12'(i), 5'd1, 3'b000, 5'd1, 7'h13}, 32'd0, 32'd0, 1'b1);
         else        cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
      end
      n_vec++;
      if (retire_cnt4 !== 4'd1) begin
         n_err++; $display("FAIL wrap_cnt4: got %0d want 1", retire_cnt4);
      end
      n_vec++;
      if (retire_cnt !== 16'd17) begin
         n_err++; $display("FAIL wrap_cnt16: got %0d want 17", retire_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_reset_midstream();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
